store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- Posted-store FIFO between the MEM stage of pipelined_mips (memwrite/dataadr/writedata) and the data memory port.
- Absorbs word stores in one cycle and drains them in order to memory under a ready handshake.
- Back-pressures the pipeline with a stall when full.
- Optionally forwards buffered store data to same-address loads.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  store request from the MEM stage.
- dataadr  input  AW  store byte address.
- writedata  input  DW  store data.
- stall  output  1  buffer full; pipeline must hold its current store.
- ld_adr  input  AW  address of the load currently in MEM.
- ld_hit  output  1  load address matches a buffered store.
- ld_data  output  DW  forwarded store data.
- mem_we  output  1  head entry valid; write request to memory.
- mem_adr  output  AW  head entry address.
- mem_wdata  output  DW  head entry data.
- mem_ready  input  1  memory accepts the write this cycle.
- count  output  log2(DEPTH)+1  occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - stall=0, mem_we=0, ld_hit=0.
  - Entry storage is not cleared.
  - Stores buffered before reset are discarded, including one mid-handshake.
- Storage: circular array of DEPTH {adr, data} entries.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
  - count is tracked separately, so full and empty are unambiguous.
- Flags:
  - full = (count==DEPTH).
  - empty = (count==0).
  - Both derived from registered state only.
- stall = full & memwrite; combinational.
- Push: memwrite & !full at a rising clk edge.
  - Entry[wr_ptr] is written with {dataadr, writedata}.
  - wr_ptr increments.
  - Stores are taken in full; no byte enables. dataadr[1:0] is stored unchanged.
- Drain:
  - mem_we = !empty.
  - mem_adr and mem_wdata are driven from entry[rd_ptr]; registered state only, no input-to-output path.
  - Pop when mem_we & mem_ready at the edge: rd_ptr increments.
  - mem_adr and mem_wdata must hold stable while mem_we=1 and mem_ready=0.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, push is refused even if a pop occurs the same cycle (no fall-through). stall stays 1 for that cycle.
- Latency:
  - A push into an empty buffer appears at mem_we on the next cycle.
  - Minimum store-to-memory latency is 1 cycle.
- Ordering: strict FIFO; no coalescing of same-address stores.
- mem_ready while empty is ignored; no pointer or count change.
- count is the registered occupancy, 0..DEPTH.

Optional Feature:
- Macro: STORE_BUF_FWD_EN.
- Defined:
  - Combinationally compare ld_adr[AW-1:2] against every valid entry's adr[AW-1:2].
  - ld_hit=1 on any match.
  - ld_data is taken from the youngest matching entry, i.e. the one closest behind wr_ptr.
  - A store being pushed in the same cycle is not visible to the compare.
  - An entry popping in the same cycle is still visible.
- Not defined: ld_hit tied 0, ld_data tied 0, no comparators synthesized.

Decomposition:
- Shared package mips_pkg holds:
  - ADDR_W=32 and DATA_W=32.
  - A packed struct store_entry_t {adr, data}.
  - A function clog2 for pointer and count widths.
- Natural sub-module: store_fwd_match.
  - Parameterised youngest-match priority selector over DEPTH entries.
  - Instantiated only under STORE_BUF_FWD_EN.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 2 cycles with memwrite=1.
  - Required: count=0, mem_we=0, stall=0 throughout.
  - Required: after release, the first push is at entry 0.
- Single store:
  - Stimulus: one store dataadr=84, writedata=7 with mem_ready=1.
  - Required: next cycle mem_we=1, mem_adr=84, mem_wdata=7.
  - Required: following cycle mem_we=0, count=0.
- Fill and stall:
  - Stimulus: mem_ready=0, then five stores to 80,84,88,92,96.
  - Required: count=4 and stall=1 on the fifth store.
  - Required: after mem_ready=1 drains one, the fifth store is accepted and drain order is 80,84,88,92,96.
- Wrap-around:
  - Stimulus: 10 stores with mem_ready toggling every cycle.
  - Required: all 10 written in order with data intact; pointers wrap twice.
- Simultaneous push/pop at count=2:
  - Required: count stays 2 and the head advances by one.
  - Stimulus: then with count=4 (full), push with mem_ready=1.
  - Required: store refused, stall=1, count becomes 3.
- Forwarding (STORE_BUF_FWD_EN):
  - Stimulus: buffer stores 84<-7 then 84<-9, with ld_adr=84 or 87.
  - Required: ld_hit=1, ld_data=9.
  - Stimulus: ld_adr=80.
  - Required: ld_hit=0.
  - Required: without the macro, ld_hit=0 always.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the pipelined_mips memory-side blocks.
//   ADDR_W / DATA_W : default address and data widths of the core
//   store_entry_t   : one posted store, {adr, data}
//   clog2           : ceiling log2, used for pointer and occupancy widths
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] data;
    } store_entry_t;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/store_write_buffer_fwd_match.sv
// store_fwd_match
// Youngest-match priority selector for store-to-load forwarding.
// The module only exists when STORE_BUF_FWD_EN is defined; the default
// build has no comparators at all.
// Ports:
//   valid   : per-entry occupancy flags (entry holds a buffered store)
//   tags    : per-entry word address adr[AW-1:2]
//   datas   : per-entry store data
//   wr_ptr  : next slot to be written; the youngest entry sits just behind it
//   ld_tag  : word address of the load currently in MEM
//   hit     : at least one valid entry matches ld_tag
//   data    : data of the youngest matching entry (0 when no hit)
`ifdef STORE_BUF_FWD_EN
module store_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = 30,
    parameter int DW    = 32
) (
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0][TW-1:0]       tags,
    input  logic [DEPTH-1:0][DW-1:0]       datas,
    input  logic [clog2(DEPTH)-1:0]        wr_ptr,
    input  logic [TW-1:0]                  ld_tag,
    output logic                           hit,
    output logic [DW-1:0]                  data
);

    localparam int PW = clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk from the oldest slot (k=DEPTH, i.e. wr_ptr itself) towards the
    // youngest (k=1, just behind wr_ptr); a later match overwrites an
    // earlier one so the youngest matching store wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = wr_ptr - PW'(k);
            if (valid[idx] && (tags[idx] == ld_tag)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule
`endif

// File: rtl/store_write_buffer.sv
// store_write_buffer
// Posted-store FIFO between the MEM stage and the data memory port. Word
// stores are absorbed in one cycle and drained in order under a ready
// handshake; the pipeline is stalled while the buffer is full.
// Optional feature macro: STORE_BUF_FWD_EN (store-to-load forwarding).
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   memwrite/dataadr/writedata : store request from MEM
//   stall                 : buffer full while a store is requested
//   ld_adr, ld_hit, ld_data : forwarding lookup for the load in MEM
//   mem_we/mem_adr/mem_wdata : head entry presented to memory
//   mem_ready             : memory accepts the head entry this cycle
//   count                 : registered occupancy, 0..DEPTH
module store_write_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    memwrite,
    input  logic [AW-1:0]           dataadr,
    input  logic [DW-1:0]           writedata,
    output logic                    stall,
    input  logic [AW-1:0]           ld_adr,
    output logic                    ld_hit,
    output logic [DW-1:0]           ld_data,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_adr,
    output logic [DW-1:0]           mem_wdata,
    input  logic                    mem_ready,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Flags come from the registered count only. A full buffer refuses a
    // push even when the head pops in the same cycle (no fall-through).
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = memwrite & ~full;
    assign pop   = ~empty & mem_ready;
    assign stall = full & memwrite;

    assign mem_we    = ~empty;
    assign mem_adr   = entries[rd_ptr].adr;
    assign mem_wdata = entries[rd_ptr].data;

    // Entry storage is deliberately not reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= {dataadr, writedata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH-1:0]          valid;
    logic [DEPTH-1:0][AW-3:0]  tags;
    logic [DEPTH-1:0][DW-1:0]  datas;
    logic [PW-1:0]             offset;
    logic                      unused_ld;

    assign unused_ld = ^ld_adr[1:0];

    // An entry is live when its distance ahead of rd_ptr is below count.
    // Only registered state is used, so a store pushed this cycle is not
    // seen and an entry popping this cycle still is.
    always_comb begin
        valid  = '0;
        tags   = '0;
        datas  = '0;
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset   = PW'(i) - rd_ptr;
            valid[i] = ({1'b0, offset} < count);
            tags[i]  = entries[i].adr[AW-1:2];
            datas[i] = entries[i].data;
        end
    end

    store_fwd_match #(
        .DEPTH (DEPTH),
        .TW    (AW - 2),
        .DW    (DW)
    ) u_fwd_match (
        .valid  (valid),
        .tags   (tags),
        .datas  (datas),
        .wr_ptr (wr_ptr),
        .ld_tag (ld_adr[AW-1:2]),
        .hit    (ld_hit),
        .data   (ld_data)
    );
`else
    logic unused_ld;

    assign unused_ld = ^ld_adr;
    assign ld_hit    = 1'b0;
    assign ld_data   = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer
// Directed bench for store_write_buffer (DEPTH=4, 32-bit address/data).
// Expected forwarding results depend on STORE_BUF_FWD_EN.
module tb_store_write_buffer;

`ifdef STORE_BUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        stall;
    logic [31:0] ld_adr = '0;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [2:0]  count;

    int tests_run = 0;
    int tests_failed = 0;

    store_write_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .stall     (stall),
        .ld_adr    (ld_adr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        memwrite = 1'b1; dataadr = 32'd100; writedata = 32'd55; mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
            tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
            tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
        end
        reset = 1'b1; memwrite = 1'b0;
        #1;
        tests_run++; if (dut.wr_ptr !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_wr_ptr got=%0d exp=0", dut.wr_ptr); end
        tick;
        dataadr = 32'd200; writedata = 32'd1; memwrite = 1'b1;
        tick;
        memwrite = 1'b0;
        tests_run++; if (dut.wr_ptr !== 2'd1) begin tests_failed++; $display("[TB] FAIL first_push_slot got=%0d exp=1", dut.wr_ptr); end
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("[TB] FAIL first_push_count got=%0d exp=1", count); end
        tests_run++; if (mem_adr !== 32'd200) begin tests_failed++; $display("[TB] FAIL first_push_adr got=%0d exp=200", mem_adr); end
        tests_run++; if (mem_wdata !== 32'd1) begin tests_failed++; $display("[TB] FAIL first_push_data got=%0d exp=1", mem_wdata); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL first_drain_count got=%0d exp=0", count); end
    endtask

    task automatic test_single_store;
        memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7; mem_ready = 1'b1;
        #1;
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_pre_we got=%b exp=0", mem_we); end
        tick;
        memwrite = 1'b0;
        tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_we got=%b exp=1", mem_we); end
        tests_run++; if (mem_adr !== 32'd84) begin tests_failed++; $display("[TB] FAIL single_adr got=%0d exp=84", mem_adr); end
        tests_run++; if (mem_wdata !== 32'd7) begin tests_failed++; $display("[TB] FAIL single_data got=%0d exp=7", mem_wdata); end
        tick;
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_after_we got=%b exp=0", mem_we); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL single_after_count got=%0d exp=0", count); end
        mem_ready = 1'b0;
    endtask

    task automatic test_fill_stall;
        int idx;
        int acc;
        mem_ready = 1'b0; memwrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dataadr = 32'(80 + 4 * i); writedata = 32'(100 + i);
            #1;
            tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_stall_%0d got=%b exp=0", i, stall); end
            tick;
        end
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fill_count got=%0d exp=4", count); end
        dataadr = 32'd96; writedata = 32'd104;
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL fifth_stall got=%b exp=1", stall); end
        tick;
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL fifth_count got=%0d exp=4", count); end
        tests_run++; if (mem_adr !== 32'd80) begin tests_failed++; $display("[TB] FAIL hold_adr got=%0d exp=80", mem_adr); end
        tests_run++; if (mem_wdata !== 32'd100) begin tests_failed++; $display("[TB] FAIL hold_data got=%0d exp=100", mem_wdata); end
        mem_ready = 1'b1;
        idx = 0;
        acc = -1;
        for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
            #1;
            if (mem_we && mem_ready) begin
                tests_run++; if (mem_adr !== 32'(80 + 4 * idx)) begin tests_failed++; $display("[TB] FAIL drain_adr_%0d got=%0d exp=%0d", idx, mem_adr, 80 + 4 * idx); end
                tests_run++; if (mem_wdata !== 32'(100 + idx)) begin tests_failed++; $display("[TB] FAIL drain_data_%0d got=%0d exp=%0d", idx, mem_wdata, 100 + idx); end
                idx++;
            end
            if (memwrite && !stall) acc = cyc;
            tick;
            if (acc >= 0) memwrite = 1'b0;
        end
        memwrite = 1'b0; mem_ready = 1'b0;
        tests_run++; if (idx != 5) begin tests_failed++; $display("[TB] FAIL drain_total got=%0d exp=5", idx); end
        tests_run++; if (acc != 1) begin tests_failed++; $display("[TB] FAIL fifth_accept_cycle got=%0d exp=1", acc); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL fill_end_count got=%0d exp=0", count); end
    endtask

    task automatic test_wrap;
        int pushed;
        int popped;
        int mcount;
        bit rdy;
        bit do_push;
        bit do_pop;
        pushed = 0; popped = 0; mcount = 0; rdy = 1'b0;
        for (int cyc = 0; cyc < 100 && popped < 10; cyc++) begin
            memwrite  = (pushed < 10);
            dataadr   = 32'(1000 + 4 * pushed + (pushed % 4));
            writedata = 32'hA000_0000 + 32'(pushed);
            mem_ready = rdy;
            #1;
            tests_run++; if (stall !== (memwrite && mcount == 4)) begin tests_failed++; $display("[TB] FAIL wrap_stall_c%0d got=%b exp=%b", cyc, stall, (memwrite && mcount == 4)); end
            tests_run++; if (count !== 3'(mcount)) begin tests_failed++; $display("[TB] FAIL wrap_count_c%0d got=%0d exp=%0d", cyc, count, mcount); end
            do_pop  = mem_ready && (mcount > 0);
            do_push = memwrite && (mcount < 4);
            if (do_pop) begin
                tests_run++; if (mem_adr !== 32'(1000 + 4 * popped + (popped % 4))) begin tests_failed++; $display("[TB] FAIL wrap_adr_%0d got=%0d exp=%0d", popped, mem_adr, 1000 + 4 * popped + (popped % 4)); end
                tests_run++; if (mem_wdata !== 32'hA000_0000 + 32'(popped)) begin tests_failed++; $display("[TB] FAIL wrap_data_%0d got=%h exp=%h", popped, mem_wdata, 32'hA000_0000 + 32'(popped)); end
                popped++;
            end
            if (do_push) pushed++;
            mcount = mcount + int'(do_push) - int'(do_pop);
            rdy = ~rdy;
            tick;
        end
        memwrite = 1'b0; mem_ready = 1'b0;
        tests_run++; if (popped != 10) begin tests_failed++; $display("[TB] FAIL wrap_total got=%0d exp=10", popped); end
    endtask

    task automatic test_back_to_back;
        mem_ready = 1'b0; memwrite = 1'b1;
        dataadr = 32'd300; writedata = 32'd30; tick;
        dataadr = 32'd304; writedata = 32'd31; tick;
        tests_run++; if (count !== 3'd2) begin tests_failed++; $display("[TB] FAIL b2b_pre_count got=%0d exp=2", count); end
        dataadr = 32'd308; writedata = 32'd32; mem_ready = 1'b1;
        tick;
        tests_run++; if (count !== 3'd2) begin tests_failed++; $display("[TB] FAIL b2b_count got=%0d exp=2", count); end
        tests_run++; if (mem_adr !== 32'd304) begin tests_failed++; $display("[TB] FAIL b2b_head got=%0d exp=304", mem_adr); end
        mem_ready = 1'b0;
        dataadr = 32'd312; writedata = 32'd33; tick;
        dataadr = 32'd316; writedata = 32'd34; tick;
        tests_run++; if (count !== 3'd4) begin tests_failed++; $display("[TB] FAIL b2b_full_count got=%0d exp=4", count); end
        dataadr = 32'd320; writedata = 32'd35; mem_ready = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_pop_stall got=%b exp=1", stall); end
        tick;
        memwrite = 1'b0;
        tests_run++; if (count !== 3'd3) begin tests_failed++; $display("[TB] FAIL full_pop_count got=%0d exp=3", count); end
        for (int k = 0; k < 3; k++) begin
            tests_run++; if (mem_adr !== 32'(308 + 4 * k)) begin tests_failed++; $display("[TB] FAIL b2b_drain_%0d got=%0d exp=%0d", k, mem_adr, 308 + 4 * k); end
            tests_run++; if (mem_wdata !== 32'(32 + k)) begin tests_failed++; $display("[TB] FAIL b2b_drain_data_%0d got=%0d exp=%0d", k, mem_wdata, 32 + k); end
            tick;
        end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_end_we got=%b exp=0", mem_we); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL b2b_end_count got=%0d exp=0", count); end
        mem_ready = 1'b0;
    endtask

    task automatic test_ready_empty;
        memwrite = 1'b0; mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL idle_count_%0d got=%0d exp=0", c, count); end
            tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL idle_we_%0d got=%b exp=0", c, mem_we); end
        end
        mem_ready = 1'b0; memwrite = 1'b1; dataadr = 32'd500; writedata = 32'd5;
        tick;
        memwrite = 1'b0;
        tests_run++; if (mem_adr !== 32'd500) begin tests_failed++; $display("[TB] FAIL idle_head got=%0d exp=500", mem_adr); end
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("[TB] FAIL idle_push_count got=%0d exp=1", count); end
        mem_ready = 1'b1;
        tick;
        mem_ready = 1'b0;
    endtask

    task automatic test_forward;
        logic        exp_hit;
        logic [31:0] exp_data;
        exp_hit = FWD;
        mem_ready = 1'b0; memwrite = 1'b1;
        dataadr = 32'd84; writedata = 32'd7;
        tick;
        dataadr = 32'd84; writedata = 32'd9; ld_adr = 32'd84;
        #1;
        exp_data = FWD ? 32'd7 : 32'd0;
        tests_run++; if (ld_hit !== exp_hit) begin tests_failed++; $display("[TB] FAIL fwd_same_cycle_hit got=%b exp=%b", ld_hit, exp_hit); end
        tests_run++; if (ld_data !== exp_data) begin tests_failed++; $display("[TB] FAIL fwd_same_cycle_data got=%0d exp=%0d", ld_data, exp_data); end
        tick;
        memwrite = 1'b0;
        exp_data = FWD ? 32'd9 : 32'd0;
        #1;
        tests_run++; if (ld_hit !== exp_hit) begin tests_failed++; $display("[TB] FAIL fwd84_hit got=%b exp=%b", ld_hit, exp_hit); end
        tests_run++; if (ld_data !== exp_data) begin tests_failed++; $display("[TB] FAIL fwd84_data got=%0d exp=%0d", ld_data, exp_data); end
        ld_adr = 32'd87;
        #1;
        tests_run++; if (ld_hit !== exp_hit) begin tests_failed++; $display("[TB] FAIL fwd87_hit got=%b exp=%b", ld_hit, exp_hit); end
        tests_run++; if (ld_data !== exp_data) begin tests_failed++; $display("[TB] FAIL fwd87_data got=%0d exp=%0d", ld_data, exp_data); end
        ld_adr = 32'd80;
        #1;
        tests_run++; if (ld_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd80_hit got=%b exp=0", ld_hit); end
        ld_adr = 32'd84; mem_ready = 1'b1;
        #1;
        tests_run++; if (ld_hit !== exp_hit) begin tests_failed++; $display("[TB] FAIL fwd_popping_hit got=%b exp=%b", ld_hit, exp_hit); end
        tick;
        tests_run++; if (ld_data !== exp_data) begin tests_failed++; $display("[TB] FAIL fwd_after_pop_data got=%0d exp=%0d", ld_data, exp_data); end
        tick;
        tests_run++; if (ld_hit !== 1'b0) begin tests_failed++; $display("[TB] FAIL fwd_empty_hit got=%b exp=0", ld_hit); end
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL fwd_end_count got=%0d exp=0", count); end
        mem_ready = 1'b0; ld_adr = 32'd0;
    endtask

    task automatic test_reset_midway;
        mem_ready = 1'b0; memwrite = 1'b1;
        dataadr = 32'd600; writedata = 32'd60; tick;
        dataadr = 32'd604; writedata = 32'd61; tick;
        memwrite = 1'b0; mem_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        tests_run++; if (count !== 3'd0) begin tests_failed++; $display("[TB] FAIL async_reset_count got=%0d exp=0", count); end
        tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_reset_we got=%b exp=0", mem_we); end
        tick;
        reset = 1'b1; mem_ready = 1'b0;
        memwrite = 1'b1; dataadr = 32'd700; writedata = 32'd70;
        tick;
        memwrite = 1'b0;
        tests_run++; if (count !== 3'd1) begin tests_failed++; $display("[TB] FAIL post_reset_count got=%0d exp=1", count); end
        tests_run++; if (mem_adr !== 32'd700) begin tests_failed++; $display("[TB] FAIL post_reset_head got=%0d exp=700", mem_adr); end
    endtask

    initial begin
        test_reset;
        test_single_store;
        test_fill_stall;
        test_wrap;
        test_back_to_back;
        test_ready_empty;
        test_forward;
        test_reset_midway;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
